// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; master drives operands, slave returns results.
interface serial_adder_if #(
  parameter int unsigned WIDTH = serial_adder_pkg::SA_DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_fa.sv
// 1-bit structural full adder cell, time-multiplexed by serial_adder.
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic ab_x;
  logic ab_a;
  logic xc_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign xc_a = ab_x & cin;
  assign s    = ab_x ^ cin;
  assign cout = ab_a | xc_a;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder cell, LSB first, registered carry between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int unsigned         CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]       LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_s;
  logic cell_co;

  structuralFullAdder u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      SA_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {cell_s, s_sh_q[WIDTH-1:1]};
        carry_d = cell_co;
        cnt_d   = cnt_q + 1'b1;
        // carry_q here is the carry into the MSB, so it feeds the overflow term
        if (cnt_q == LAST) begin
          sum_d   = s_sh_d;
          cout_d  = cell_co;
          ovf_d   = carry_q ^ cell_co;
          state_d = SA_DONE;
        end
      end
      SA_DONE: begin
        if (bus.out_ready) state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SA_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == SA_IDLE);
  assign bus.out_valid = (state_q == SA_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that time-multiplexes a single 1-bit full adder cell. It accepts two operands and a carry-in over a valid/ready handshake, then adds one bit per clock, LSB first, using a registered carry. It presents the sum, carry-out and signed overflow on a valid/ready output port. It sits directly upstream of the full adder cell: it sequences operand bits into the cell and consumes the cell's sum and carry outputs. This is the team's area-minimal adder for multi-bit datapaths.

## Interface
- WIDTH, 8: operand and sum width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- out_valid  output  1  sum, cout and overflow are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow, defined as carry into the MSB XOR cout.

## Operation
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - All shift registers, the bit counter and the carry register clear to 0.
  - Outputs: sum=0, cout=0, overflow=0, out_valid=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid & in_ready: load a into a_sh, load b into b_sh, set carry=cin, set cnt=0, then go to RUN.
- RUN, one edge per bit:
  - Cell inputs are a_sh[0], b_sh[0] and carry.
  - a_sh and b_sh shift right.
  - The cell's sum output shifts into the MSB of s_sh.
  - carry <= cell cout; cnt++.
  - On the edge where cnt==WIDTH-1:
    - sum <= final s_sh value.
    - cout <= cell cout.
    - overflow <= carry (the carry into the MSB) XOR cell cout.
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and overflow are held stable.
  - When out_ready is high, go to IDLE on that edge.
- Result outputs change only on entry to DONE. They keep their last value in IDLE and RUN.
- Inputs are ignored outside the IDLE accept cycle. Changes to a, b or cin during RUN or DONE have no effect.
- Arithmetic is modulo 2^WIDTH with a separate cout. It computes the same {cout,sum} as a+b+cin.

## Timing
- Latency: operands are accepted on edge E; out_valid rises after edge E+WIDTH.
- Earliest next accept:
  - With out_ready held high, DONE lasts 1 cycle, so IDLE is entered at edge E+WIDTH+1.
  - Minimum initiation interval is WIDTH+2 cycles.
- No same-cycle turnaround: in_ready is 0 throughout DONE, so accept and result handoff never coincide.
- Backpressure: DONE persists indefinitely while out_ready=0, and outputs stay frozen.
- Reset mid-operation (RUN or DONE):
  - Immediate abort to IDLE with reset values.
  - No out_valid pulse; the partial result is discarded.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- The cell is combinational with 50-unit gate delays and a worst-case cout path of 150 units. The bench clock period is 200 time units minimum.

## Structure
- Shared header/package, included by RTL and bench:
  - State encodings: SA_IDLE=2'd0, SA_RUN=2'd1, SA_DONE=2'd2.
  - Default width constant (8).
  - Gate-delay macros, already shared.
- Sub-module: one instance of the existing 1-bit structural full adder, `structuralFullAdder`.
- The FSM, shift registers, counter (width $clog2(WIDTH)+1) and carry flop live in `serial_adder`.

## Test plan
- 8'h3C + 8'h05, cin=0, accepted at edge E: out_valid first high after edge E+8, sum=8'h41, cout=0, overflow=0.
- 8'hFF + 8'h01, cin=0: sum=8'h00, cout=1, overflow=0.
- 8'h7F + 8'h01, cin=0: sum=8'h80, cout=0, overflow=1.
- 8'h80 + 8'h80, cin=1: sum=8'h01, cout=1, overflow=1.
- Backpressure check:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: outputs stay constant, in_ready=0, and the new operands are not accepted.
  - Required after raising out_ready: IDLE next cycle, and the next transaction completes correctly.
- Reset check:
  - Stimulus: pull rst_n low asynchronously, mid-cycle, during RUN after 3 bits.
  - Required: out_valid=0, in_ready=1 and sum=0 immediately.
  - Required after release: 8'h12 + 8'h34, cin=0 gives sum=8'h46 with latency 8.
